// File: rtl/rv_boot_loader.sv
// Framed byte-stream program loader: writes an image into instruction memory and holds the core in reset until the checksum matches.
// Optional inter-byte timeout compiled in with `BOOT_TIMEOUT_EN.
module rv_boot_loader #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CKSUM  = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    if ((DEPTH > (2 ** ADDR_W)) || (DEPTH > 65535) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("rv_boot_loader: illegal DEPTH/ADDR_W/TIMEOUT_CYCLES combination");
    end

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept_s;
    logic              timeout_s;
    logic [15:0]       len_rx_s;

    assign accept_s = rx_valid && rx_ready_q;
    assign len_rx_s = {rx_data, len_lo_q};

`ifdef BOOT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Inter-byte watchdog: runs only while a frame is in flight.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (accept_s || (state_d == S_LEN_LO)) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if ((state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CKSUM)) begin
            to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_s = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_LEN_LO;
            len_lo_q     <= 8'h00;
            len_q        <= 16'h0000;
            word_cnt_q   <= 16'h0000;
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'h000000;
            sum_q        <= 8'h00;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 32'h00000000;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            sum_q        <= sum_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state decode; a stalled link holds the state unless the watchdog fires.
    always_comb begin
        state_d = state_q;
        if (accept_s) begin
            case (state_q)
                S_LEN_LO: state_d = S_LEN_HI;
                S_LEN_HI: begin
                    if ({1'b0, len_rx_s} > 17'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_rx_s == 16'h0000) begin
                        state_d = S_CKSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if ((byte_cnt_q == 2'd3) && (word_cnt_q == (len_q - 16'd1))) begin
                        state_d = S_CKSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CKSUM: state_d = (rx_data == sum_q) ? S_RUN : S_ERR;
                default: state_d = state_q;
            endcase
        end else if (timeout_s && ((state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CKSUM))) begin
            state_d = S_ERR;
        end else begin
            state_d = state_q;
        end
    end

    // Outputs follow the next state so they change on the accepting edge; words assemble LSB first.
    always_comb begin
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        sum_d        = sum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_d)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM: begin
                rx_ready_d   = 1'b1;
                core_reset_d = 1'b1;
                done_d       = 1'b0;
                error_d      = 1'b0;
            end
            S_RUN: begin
                rx_ready_d   = 1'b0;
                core_reset_d = 1'b0;
                done_d       = 1'b1;
                error_d      = 1'b0;
            end
            default: begin
                rx_ready_d   = 1'b0;
                core_reset_d = 1'b1;
                done_d       = 1'b0;
                error_d      = 1'b1;
            end
        endcase
        if (accept_s) begin
            case (state_q)
                S_LEN_LO: len_lo_d = rx_data;
                S_LEN_HI: len_d = len_rx_s;
                S_DATA: begin
                    sum_d      = sum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = {rx_data, word_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = {rx_data, word_q};
                        word_cnt_d   = word_cnt_q + 16'd1;
                    end else begin
                        imem_we_d    = 1'b0;
                    end
                end
                default: begin
                    len_lo_d = len_lo_q;
                end
            endcase
        end else begin
            len_lo_d = len_lo_q;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_rv_boot_loader.sv
// Directed self-checking bench for rv_boot_loader.
module tb_rv_boot_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int          n_vec;
    int          n_miss;
    int          wr_cnt;
    int          base;
    logic [7:0]  wa_log [0:63];
    logic [31:0] wd_log [0:63];

    rv_boot_loader #(
        .DEPTH(256),
        .ADDR_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial wr_cnt = 0;
    // Log every write-strobe cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wa_log[wr_cnt] = imem_addr;
                wd_log[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while ((rx_ready !== 1'b1) && (waited < 50)) begin
            waited = waited + 1;
            @(negedge clk);
        end
        if (rx_ready !== 1'b1) begin
            check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic send_good(input logic [7:0] ck, input int max_gap);
        logic [7:0] fr [0:10];
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        fr[10] = ck;
        for (int i = 0; i < 11; i++) begin
            idle($urandom_range(max_gap, 0));
            send_byte(fr[i]);
        end
    endtask

    task automatic check_good_writes(input string tag, input int b);
        check({tag, "_wcount"}, wr_cnt - b, 32'd2);
        check({tag, "_addr0"}, {24'd0, wa_log[b]}, 32'd0);
        check({tag, "_data0"}, wd_log[b], 32'h00000013);
        check({tag, "_addr1"}, {24'd0, wa_log[b+1]}, 32'd1);
        check({tag, "_data1"}, wd_log[b+1], 32'h00100093);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b1;
        idle(1);
        check("post_rst_ready", {31'd0, rx_ready}, 32'd1);

        // Good two-word load with strobe timing checks.
        base = wr_cnt;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("w0_we", {31'd0, imem_we}, 32'd1);
        check("w0_addr", {24'd0, imem_addr}, 32'd0);
        check("w0_data", imem_wdata, 32'h00000013);
        idle(1);
        check("w0_we_low", {31'd0, imem_we}, 32'd0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check("pre_ck_core_reset", {31'd0, core_reset}, 32'd1);
        check("pre_ck_done", {31'd0, done}, 32'd0);
        send_byte(8'hB6);
        check("good_core_reset", {31'd0, core_reset}, 32'd0);
        check("good_done", {31'd0, done}, 32'd1);
        check("good_error", {31'd0, error}, 32'd0);
        check("good_ready", {31'd0, rx_ready}, 32'd0);
        check_good_writes("good", base);

        // Bad checksum.
        do_reset();
        base = wr_cnt;
        send_good(8'hB7, 0);
        check("badck_error", {31'd0, error}, 32'd1);
        check("badck_core_reset", {31'd0, core_reset}, 32'd1);
        check("badck_ready", {31'd0, rx_ready}, 32'd0);
        check("badck_done", {31'd0, done}, 32'd0);
        rx_data = 8'h00; rx_valid = 1'b1;
        idle(8);
        rx_valid = 1'b0;
        check("badck_wcount", wr_cnt - base, 32'd2);
        check("badck_sticky", {31'd0, error}, 32'd1);

        // Empty image.
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_core_reset", {31'd0, core_reset}, 32'd0);
        check("empty_wcount", wr_cnt - base, 32'd0);

        // Checksum wraps modulo 256: 4*0xFF = 0x3FC.
        do_reset();
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        send_byte(8'hFC);
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_wcount", wr_cnt - base, 32'd1);
        check("wrap_data", wd_log[base], 32'hFFFFFFFF);

        // Oversize: N = 257.
        do_reset();
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h01);
        check("over_error", {31'd0, error}, 32'd1);
        check("over_ready", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'h00; rx_valid = 1'b1;
        idle(10);
        rx_valid = 1'b0;
        check("over_wcount", wr_cnt - base, 32'd0);
        check("over_done", {31'd0, done}, 32'd0);

        // Good load with random valid gaps.
        do_reset();
        base = wr_cnt;
        send_good(8'hB6, 5);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_core_reset", {31'd0, core_reset}, 32'd0);
        check_good_writes("stall", base);

        // Reset after 5 payload bytes, then a full good frame.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h93);
        reset = 1'b0;
        idle(1);
        check("midrst_core_reset", {31'd0, core_reset}, 32'd1);
        check("midrst_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        idle(1);
        reset = 1'b1;
        idle(1);
        base = wr_cnt;
        send_good(8'hB6, 0);
        check("midrst_done_after", {31'd0, done}, 32'd1);
        check_good_writes("midrst", base);

`ifdef BOOT_TIMEOUT_EN
        // Timeout 16 cycles after the LEN_HI accept.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        idle(15);
        check("to_not_yet", {31'd0, error}, 32'd0);
        idle(1);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_ready", {31'd0, rx_ready}, 32'd0);

        // Idle link in LEN_LO never times out.
        do_reset();
        idle(100);
        check("idle_no_error", {31'd0, error}, 32'd0);
        check("idle_ready", {31'd0, rx_ready}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
